// File: rtl/cache_fill_fsm.sv
// Cache block fill controller: on a miss, issues eight word reads for the aligned
// 16-byte block and streams the returned words into the data array, tagging on the last.
module cache_fill_fsm #(
    parameter int WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic [15:0] memory_data,
    input  logic        memory_data_valid,
    output logic        fsm_busy,
    output logic        mem_req,
    output logic [15:0] memory_address,
    output logic        write_data_array,
    output logic        write_tag_array,
    output logic [7:0]  word_enable,
    output logic [15:0] fill_data,
    output logic [6:0]  fill_block
);

    typedef enum logic {
        IDLE,
        FILL
    } fillState;

    fillState    state;
    fillState    nextState;
    logic [15:0] base;
    logic [3:0]  reqCnt;
    logic [3:0]  rcvCnt;
    logic        reqPending;
    logic        lastWord;
    logic [2:0]  reqIdx;

    assign reqPending = (reqCnt < 4'(WORDS));
    assign lastWord   = (rcvCnt == 4'(WORDS - 1));
    // Once all requests are out the address parks on the final word of the block.
    assign reqIdx     = reqPending ? reqCnt[2:0] : 3'(WORDS - 1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            base   <= '0;
            reqCnt <= '0;
            rcvCnt <= '0;
        end else if (state == IDLE) begin
            if (miss_detected) begin
                base   <= miss_address & 16'hFFF0;
                reqCnt <= '0;
                rcvCnt <= '0;
            end
        end else begin
            if (reqPending) begin
                reqCnt <= reqCnt + 4'd1;
            end
            if (memory_data_valid) begin
                rcvCnt <= rcvCnt + 4'd1;
            end
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: if (miss_detected) nextState = FILL;
            FILL: if (memory_data_valid && lastWord) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // NOTE: every output gets a default first so no path leaves one unassigned
    // (which would infer a latch).
    always_comb begin
        fsm_busy         = 1'b0;
        mem_req          = 1'b0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        word_enable      = 8'h00;
        fill_data        = memory_data;
        fill_block       = base[10:4];
        memory_address   = base + {12'h000, reqIdx, 1'b0};
        if (state == FILL) begin
            fsm_busy = 1'b1;
            mem_req  = reqPending;
            if (memory_data_valid) begin
                write_data_array = 1'b1;
                write_tag_array  = lastWord;
                word_enable      = 8'h01 << rcvCnt[2:0];
            end
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: directed vector table, hand-written fill
// scenarios and randomized traffic, all compared against a block-level fill model.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        mem_req;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic        write_tag_array;
    logic [7:0]  word_enable;
    logic [15:0] fill_data;
    logic [6:0]  fill_block;

    always #5 clk = ~clk;

    cache_fill_fsm #(.WORDS(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .mem_req           (mem_req),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .word_enable       (word_enable),
        .fill_data         (fill_data),
        .fill_block        (fill_block)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: a fill in progress, its block base, words requested and words received.
    bit mBusy;
    int mBase;
    int mReq;
    int mRcv;

    typedef struct {
        logic        m;
        logic [15:0] a;
        logic        v;
        logic [15:0] d;
        logic        eBusy;
        logic        eReq;
        logic        eWr;
        logic        eTag;
        logic [7:0]  eWe;
        logic [15:0] eAddr;
    } vecT;

    vecT vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic m, input logic [15:0] a,
                         input logic v, input logic [15:0] d);
        @(negedge clk);
        rst               = r;
        miss_detected     = m;
        miss_address      = a;
        memory_data_valid = v;
        memory_data       = d;
        #1;
    endtask

    task automatic checkModel();
        int  idx;
        bit  eWr;
        idx = (mReq < 8) ? mReq : 7;
        eWr = mBusy && memory_data_valid;
        check("busy", 32'(fsm_busy), 32'(mBusy));
        check("mem_req", 32'(mem_req), 32'(mBusy && mReq < 8));
        check("mem_addr", 32'(memory_address), (mBase + 2 * idx) & 32'hFFFF);
        check("wr_data", 32'(write_data_array), 32'(eWr));
        check("wr_tag", 32'(write_tag_array), 32'(eWr && mRcv == 7));
        check("word_en", 32'(word_enable), eWr ? (32'd1 << mRcv) : 32'd0);
        check("fill_block", 32'(fill_block), (mBase >> 4) & 32'h7F);
        if (eWr) check("fill_data", 32'(fill_data), 32'(memory_data));
    endtask

    task automatic advance();
        @(posedge clk);
        if (!rst) begin
            mBusy = 0;
            mBase = 0;
            mReq  = 0;
            mRcv  = 0;
        end else if (!mBusy) begin
            if (miss_detected) begin
                mBusy = 1;
                mBase = int'(miss_address) & 32'hFFF0;
                mReq  = 0;
                mRcv  = 0;
            end
        end else begin
            if (mReq < 8) mReq++;
            if (memory_data_valid) begin
                if (mRcv == 7) mBusy = 0;
                mRcv++;
            end
        end
    endtask

    task automatic step(input logic r, input logic m, input logic [15:0] a,
                        input logic v, input logic [15:0] d);
        drive(r, m, a, v, d);
        checkModel();
        advance();
    endtask

    initial begin
        int busyCnt;

        vecs[0] = '{1'b0, 16'h0000, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000};
        vecs[1] = '{1'b0, 16'hFFFF, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000};
        vecs[2] = '{1'b1, 16'h1236, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000};
        vecs[3] = '{1'b0, 16'h0000, 1'b1, 16'hA000, 1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 16'h1230};
        vecs[4] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'h1232};
        vecs[5] = '{1'b0, 16'h0000, 1'b1, 16'hA002, 1'b1, 1'b1, 1'b1, 1'b0, 8'h02, 16'h1234};

        rst = 1'b0; miss_detected = 1'b0; miss_address = '0;
        memory_data = '0; memory_data_valid = 1'b0;
        mBusy = 0; mBase = 0; mReq = 0; mRcv = 0;
        repeat (2) @(posedge clk);

        // Reset state and idle behaviour, then the first cycles of a fill.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vecs[i].m, vecs[i].a, vecs[i].v, vecs[i].d);
            check($sformatf("vec%0d_busy", i), 32'(fsm_busy), 32'(vecs[i].eBusy));
            check($sformatf("vec%0d_req", i), 32'(mem_req), 32'(vecs[i].eReq));
            check($sformatf("vec%0d_wr", i), 32'(write_data_array), 32'(vecs[i].eWr));
            check($sformatf("vec%0d_tag", i), 32'(write_tag_array), 32'(vecs[i].eTag));
            check($sformatf("vec%0d_we", i), 32'(word_enable), 32'(vecs[i].eWe));
            check($sformatf("vec%0d_addr", i), 32'(memory_address), 32'(vecs[i].eAddr));
            if (vecs[i].eWr) check($sformatf("vec%0d_data", i), 32'(fill_data), 32'(vecs[i].d));
            advance();
        end
        step(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);

        // Miss at 1236 with four-cycle memory latency.
        step(1'b1, 1'b1, 16'h1236, 1'b0, 16'h0);
        busyCnt = 0;
        for (int k = 0; k < 14; k++) begin
            drive(1'b1, 1'b0, 16'h0, (k >= 4 && k < 12), 16'($urandom));
            checkModel();
            if (fsm_busy) busyCnt++;
            if (k == 0) check("lat4_block", 32'(fill_block), 32'h23);
            if (k == 11) begin
                check("lat4_tag", 32'(write_tag_array), 32'd1);
                check("lat4_we_last", 32'(word_enable), 32'h80);
            end
            advance();
        end
        check("lat4_busy_cycles", 32'(busyCnt), 32'd12);

        // Same-cycle memory: fill completes in eight FILL cycles.
        step(1'b1, 1'b1, 16'($urandom), 1'b0, 16'h0);
        busyCnt = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, 16'h0, 1'b1, 16'($urandom));
            checkModel();
            if (fsm_busy) busyCnt++;
            advance();
        end
        check("same_cycle_busy_cycles", 32'(busyCnt), 32'd8);
        drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        check("same_cycle_idle_after", 32'(fsm_busy), 32'd0);
        advance();

        // Valids every other cycle.
        step(1'b1, 1'b1, 16'h7F0E, 1'b0, 16'h0);
        for (int k = 0; k < 18; k++) begin
            step(1'b1, 1'b0, 16'h0, (k % 2 == 0), 16'($urandom));
        end

        // Miss held high with a changing address; next miss accepted in the first IDLE cycle.
        step(1'b1, 1'b1, 16'h4442, 1'b0, 16'h0);
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 1'b1, 16'($urandom), (k >= 4), 16'($urandom));
        end
        step(1'b1, 1'b1, 16'hABC0, 1'b0, 16'h0);
        drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        checkModel();
        check("back2back_busy", 32'(fsm_busy), 32'd1);
        check("back2back_block", 32'(fill_block), 32'h3C);
        check("back2back_addr", 32'(memory_address), 32'hABC0);
        advance();
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 16'h0, 1'b1, 16'($urandom));

        // Reset after the third word aborts the fill; stray valids afterwards write nothing.
        step(1'b1, 1'b1, 16'h5678, 1'b0, 16'h0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 16'h0, 1'b1, 16'($urandom));
        step(1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        drive(1'b1, 1'b0, 16'h0, 1'b1, 16'hBEEF);
        check("abort_busy", 32'(fsm_busy), 32'd0);
        check("abort_wr", 32'(write_data_array), 32'd0);
        check("abort_we", 32'(word_enable), 32'd0);
        check("abort_addr", 32'(memory_address), 32'd0);
        check("abort_block", 32'(fill_block), 32'd0);
        advance();
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 16'h0, 1'b1, 16'($urandom));

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(199) != 0), ($urandom_range(3) == 0), 16'($urandom),
                 ($urandom_range(2) != 0), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 Parameter WORDS, default 8: 16-bit words per cache block; fixed at 8 for this design (16-byte block, 128 blocks).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-004 miss_detected  input  1  cache lookup missed this cycle; sampled only in IDLE.
REQ-005 miss_address  input  16  byte address of missing access.
REQ-006 memory_data  input  16  word returned by main memory.
REQ-007 memory_data_valid  input  1  memory_data valid this cycle; one word per asserted cycle, in request order.
REQ-008 fsm_busy  output  1  fill in progress; pipeline stalls while high.
REQ-009 mem_req  output  1  memory read request this cycle.
REQ-010 memory_address  output  16  byte address of current memory request.
REQ-011 write_data_array  output  1  write strobe to data array.
REQ-012 write_tag_array  output  1  write strobe to metadata (tag) array.
REQ-013 word_enable  output  8  one-hot word select within block for the data-array write.
REQ-014 fill_data  output  16  word to write into data array (memory_data passthrough).
REQ-015 fill_block  output  7  block index (base[10:4]) being filled.

Function
REQ-016 The block SHALL implement two states: IDLE and FILL.
REQ-017 In IDLE with miss_detected=1, the block SHALL latch base = {miss_address[15:4], 4'b0}, clear req_cnt and rcv_cnt (4-bit each), and enter FILL next cycle.
REQ-018 In IDLE, fsm_busy, mem_req, write_data_array and write_tag_array SHALL be 0; memory_data_valid SHALL be ignored.
REQ-019 In FILL, fsm_busy SHALL be 1 every cycle, including the cycle the last word is written.
REQ-020 In FILL, mem_req SHALL be 1 while req_cnt < 8; memory_address = base + 2*req_cnt; req_cnt increments each such cycle, saturating at 8 (one request per cycle, 8 consecutive cycles).
REQ-021 When req_cnt = 8, mem_req SHALL be 0 and memory_address SHALL hold base + 14.
REQ-022 In FILL with memory_data_valid=1, the block SHALL assert write_data_array combinationally that cycle, with word_enable = 1 << rcv_cnt[2:0] and fill_data = memory_data, then increment rcv_cnt.
REQ-023 word_enable SHALL be 8'h00 whenever write_data_array=0.
REQ-024 On the valid cycle with rcv_cnt = 7, the block SHALL also assert write_tag_array and return to IDLE next cycle.
REQ-025 Memory returning data in the same cycle as a request SHALL be handled; req_cnt and rcv_cnt advance independently.
REQ-026 miss_detected in FILL SHALL be ignored; base SHALL NOT change until the next IDLE acceptance.
REQ-027 A miss asserted in the first IDLE cycle after a fill SHALL be accepted (no dead cycle beyond that IDLE cycle).
REQ-028 fill_block SHALL equal base[10:4] in all states.
REQ-029 Address arithmetic SHALL be 16-bit; base+14 never carries past bit 3.

Reset
REQ-030 With rst=0 at a rising edge: state=IDLE, base=16'h0000, req_cnt=0, rcv_cnt=0.
REQ-031 During and after reset: fsm_busy=0, mem_req=0, write_data_array=0, write_tag_array=0, word_enable=8'h00, memory_address=16'h0000, fill_block=7'h00.
REQ-032 Reset asserted mid-FILL SHALL abort the fill; no further writes issue; memory_data_valid arriving after reset is ignored.

Verification
REQ-033 Miss at 16'h1236, memory 4-cycle latency -> base 16'h1230; requests 1230,1232,...,123E on 8 consecutive cycles; 8 writes with word_enable 01,02,...,80; write_tag_array with word_enable 80; fill_block 7'h23; fsm_busy high 12 cycles.
REQ-034 Same-cycle memory (valid on each request cycle) -> writes coincide with requests; fill completes in 8 FILL cycles; IDLE next.
REQ-035 Gapped valids (valid every other cycle) -> rcv_cnt advances only on valid; tag write only with 8th word; mem_req low after 8 requests.
REQ-036 miss_detected held high throughout a fill with changing miss_address -> base unchanged; new miss (16'hABC0) accepted in first IDLE cycle after completion.
REQ-037 rst=0 after 3rd word written -> next cycle IDLE, all outputs at reset values; later stray valids produce no writes.
REQ-038 memory_data_valid pulses in IDLE with no miss -> no write strobes, fsm_busy stays 0.
